dense_mac_ctrl: RTL

DENSE_MAC_CTRL -- requirements
Module: dense_mac_ctrl

---
 rtl/mnist_pkg.sv | 11 +
 rtl/dense_mac_ctrl_if.sv | 34 +++
 rtl/dense_mac_acc.sv | 76 +++++++
 rtl/dense_mac_ctrl.sv | 130 +++++++++++++
 4 files changed

// File: rtl/mnist_pkg.sv
// Shared numeric types for the MNIST datapath: fixed-point width and fraction bits.
// Used by dense_mac_ctrl and dense_mac_acc.
package mnist_pkg;

  localparam int FEAT_W    = 16;
  localparam int FRAC_BITS = 8;

  typedef logic signed [FEAT_W-1:0] feature_type;
  typedef logic signed [FEAT_W-1:0] weight_type;

endpackage

// File: rtl/dense_mac_ctrl_if.sv
// Memory-side bus of dense_mac_ctrl: input/weight/bias read ports and output write port.
// master = layer controller, slave = buffer memories.
interface dense_mac_ctrl_if
  import mnist_pkg::*;
#(
  parameter int IN_LEN  = 196,
  parameter int OUT_LEN = 128
);

  localparam int IA_W = $clog2(IN_LEN);
  localparam int WA_W = $clog2(OUT_LEN * IN_LEN);
  localparam int OA_W = $clog2(OUT_LEN);

  logic [IA_W-1:0] in_addr;
  feature_type     in_data;
  logic [WA_W-1:0] w_addr;
  weight_type      w_data;
  logic [OA_W-1:0] b_addr;
  feature_type     b_data;
  logic            out_we;
  logic [OA_W-1:0] out_addr;
  feature_type     out_data;

  modport master (
    output in_addr, w_addr, b_addr, out_we, out_addr, out_data,
    input  in_data, w_data, b_data
  );

  modport slave (
    input  in_addr, w_addr, b_addr, out_we, out_addr, out_data,
    output in_data, w_data, b_data
  );

endinterface

// File: rtl/dense_mac_acc.sv
// Neuron datapath: one signed multiplier, wide accumulator, shift, narrowing and ReLU.
// Narrowing saturates when DENSE_MAC_SAT_EN is defined, otherwise wraps.
module dense_mac_acc
  import mnist_pkg::*;
#(
  parameter int IN_LEN = 196,
  parameter int RELU   = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        add_i,
  input  feature_type b_data_i,
  input  feature_type in_data_i,
  input  weight_type  w_data_i,
  output feature_type result_o
);

  localparam int ACC_W = 2 * FEAT_W + $clog2(IN_LEN);

  logic signed [2*FEAT_W-1:0] prod;
  logic signed [ACC_W-1:0]    bias_ext;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [ACC_W-1:0]    acc_d;
  logic signed [ACC_W-1:0]    shifted;
  feature_type                narrowed;

  assign prod     = in_data_i * w_data_i;
  assign bias_ext = {{(ACC_W-FEAT_W){b_data_i[FEAT_W-1]}}, b_data_i};
  assign prod_ext = {{(ACC_W-2*FEAT_W){prod[2*FEAT_W-1]}}, prod};

  always_comb begin
    acc_d = acc_q;
    if (load_i) begin
      acc_d = bias_ext <<< FRAC_BITS;
    end else if (add_i) begin
      acc_d = acc_q + prod_ext;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign shifted = acc_q >>> FRAC_BITS;

`ifdef DENSE_MAC_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (FEAT_W-1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

  always_comb begin
    if (shifted > SAT_MAX) begin
      narrowed = feature_type'(SAT_MAX);
    end else if (shifted < SAT_MIN) begin
      narrowed = feature_type'(SAT_MIN);
    end else begin
      narrowed = feature_type'(shifted);
    end
  end
`else
  assign narrowed = feature_type'(shifted);
`endif

  always_comb begin
    result_o = narrowed;
    if (RELU != 0 && narrowed[FEAT_W-1]) begin
      result_o = '0;
    end
  end

endmodule

// File: rtl/dense_mac_ctrl.sv
// Dense-layer controller: walks neurons through BIAS, MAC, DRAIN, WRITE, then DONE.
// Optional output saturation is compiled in with DENSE_MAC_SAT_EN (see dense_mac_acc).
module dense_mac_ctrl
  import mnist_pkg::*;
#(
  parameter int IN_LEN  = 196,
  parameter int OUT_LEN = 128,
  parameter int RELU    = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  dense_mac_ctrl_if.master  mem
);

  localparam int IA_W = $clog2(IN_LEN);
  localparam int WA_W = $clog2(OUT_LEN * IN_LEN);
  localparam int OA_W = $clog2(OUT_LEN);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_BIAS  = 3'd1;
  localparam logic [2:0] S_MAC   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]      state_q, state_d;
  logic [OA_W-1:0] o_q, o_d;
  logic [IA_W-1:0] i_q, i_d;
  logic [WA_W-1:0] w_q, w_d;

  logic            i_last;
  logic            o_last;
  logic            acc_load;
  logic            acc_add;
  feature_type     acc_result;

  assign i_last = (i_q == IA_W'(IN_LEN - 1));
  assign o_last = (o_q == OA_W'(OUT_LEN - 1));

  // w_q runs continuously across neurons, so it equals o*IN_LEN+i without a multiply.
  always_comb begin
    state_d = state_q;
    o_d     = o_q;
    i_d     = i_q;
    w_d     = w_q;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_BIAS;
          o_d     = '0;
          i_d     = '0;
          w_d     = '0;
        end
      end
      S_BIAS: begin
        state_d = S_MAC;
        i_d     = '0;
      end
      S_MAC: begin
        w_d = w_q + WA_W'(1);
        if (i_last) begin
          state_d = S_DRAIN;
          i_d     = '0;
        end else begin
          i_d = i_q + IA_W'(1);
        end
      end
      S_DRAIN: state_d = S_WRITE;
      S_WRITE: begin
        if (o_last) begin
          state_d = S_DONE;
        end else begin
          state_d = S_BIAS;
          o_d     = o_q + OA_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      o_q     <= '0;
      i_q     <= '0;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      o_q     <= o_d;
      i_q     <= i_d;
      w_q     <= w_d;
    end
  end

  // Bias arrives during the first MAC cycle; products lag their addresses by one cycle.
  assign acc_load = (state_q == S_MAC) && (i_q == '0);
  assign acc_add  = ((state_q == S_MAC) && (i_q != '0)) || (state_q == S_DRAIN);

  dense_mac_acc #(
    .IN_LEN (IN_LEN),
    .RELU   (RELU)
  ) u_acc (
    .clk_i     (clock),
    .rst_i     (reset),
    .load_i    (acc_load),
    .add_i     (acc_add),
    .b_data_i  (mem.b_data),
    .in_data_i (mem.in_data),
    .w_data_i  (mem.w_data),
    .result_o  (acc_result)
  );

  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign mem.b_addr   = (state_q == S_BIAS)  ? o_q : '0;
  assign mem.in_addr  = (state_q == S_MAC)   ? i_q : '0;
  assign mem.w_addr   = (state_q == S_MAC)   ? w_q : '0;
  assign mem.out_we   = (state_q == S_WRITE);
  assign mem.out_addr = (state_q == S_WRITE) ? o_q : '0;
  assign mem.out_data = (state_q == S_WRITE) ? acc_result : '0;

endmodule
